rcl_driver: RTL and testbench
=============================

Name: rcl_driver

Overview:
- Initiator for the circle/line relation block (RCL) serial interface.
- Accepts one parallel request holding circle centre (m,n), squared radius k and line coefficients (a,b,c) over a valid/ready handshake.
- Serializes the request into the 3-cycle in_valid/coef_Q/coef_L burst, waits for the out_valid/out result, and returns it on a response handshake.
- Keeps per-class result counters and detects timeouts and stray results; sits between the host-side controller and RCL.

Parameters:
- TIMEOUT, 16, maximum WAIT cycles before declaring timeout (legal range 6..255).
- CNT_W, 8, width of the saturating result counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  driver can accept a request
- req_m  in  5  circle centre x, signed
- req_n  in  5  circle centre y, signed
- req_k  in  5  squared radius, unsigned
- req_a  in  5  line coefficient a, signed
- req_b  in  5  line coefficient b, signed
- req_c  in  5  line coefficient c, signed
- rcl_in_valid  out  1  burst valid to RCL
- rcl_coef_Q  out  5  circle coefficient lane
- rcl_coef_L  out  5  line coefficient lane
- rcl_out_valid  in  1  result valid from RCL
- rcl_out  in  2  result from RCL: 0 = separate, 1 = tangent, 2 = crossing
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_class  out  2  captured result; 3 means timeout
- resp_timeout  out  1  response produced by timeout
- stray_err  out  1  sticky: rcl_out_valid seen outside WAIT
- cnt_sep  out  CNT_W  count of results equal to 0
- cnt_tan  out  CNT_W  count of results equal to 1
- cnt_cross  out  CNT_W  count of results equal to 2

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; all outputs 0, including counters and stray_err. Reset mid-burst drops rcl_in_valid immediately.
- States: IDLE, SEND0, SEND1, SEND2, WAIT, RESP.
- All RCL-side outputs and response outputs are registered.
- req_ready is 1 only in IDLE, decoded directly from the state register.
- IDLE -> SEND0 on req_valid && req_ready.
  - The request is latched into internal registers at that edge.
  - Output registers load m on coef_Q and a on coef_L, with rcl_in_valid = 1.
- SEND0 -> SEND1: drive n / b.
- SEND1 -> SEND2: drive k / c.
- SEND2 -> WAIT: rcl_in_valid and both coef lanes return to 0.
- Burst timing: exactly 3 consecutive rcl_in_valid cycles; no gaps, no extension.
- WAIT:
  - The WAIT counter starts at 0 and increments each cycle.
  - On rcl_out_valid: capture rcl_out into resp_class, set resp_timeout = 0, increment the matching counter, go to RESP.
  - A value of 3 is passed through and counts nothing.
  - Nominal RCL latency: out_valid arrives in the 5th WAIT cycle.
- Timeout: if the counter reaches TIMEOUT-1 with no rcl_out_valid, set resp_class = 3 and resp_timeout = 1, and go to RESP.
- RESP:
  - resp_valid = 1; resp_class and resp_timeout are held stable until resp_ready.
  - On resp_valid && resp_ready: clear resp_valid and go to IDLE.
- Back-to-back requests: the next burst starts no earlier than 2 cycles after rcl_out_valid, so RCL is guaranteed back in IDLE.
- Counters saturate at all-ones and never wrap.
- Stray results: rcl_out_valid in any state other than WAIT sets stray_err (sticky until reset). It does not change counters, state or the response.
- Simultaneous events: rcl_out_valid in the same cycle as timeout expiry counts as a valid result; the result wins over the timeout.
- The request is never dropped: req_ready stays low from acceptance until the response handshake completes.

Decomposition:
- Shared package rcl_pkg:
  - state enum
  - coefficient width constant (5)
  - result codes REL_SEP = 0, REL_TAN = 1, REL_CROSS = 2, REL_TIMEOUT = 3
- One sub-module: rcl_sat_cnt, a CNT_W-bit saturating incrementer with enable, instantiated three times.

Test Plan:
- Tangent: m=0, n=0, k=4, a=1, b=0, c=-2 against an RCL model:
  - bursts are (0,1), (0,0), (4,-2) on consecutive cycles;
  - resp_class = 1, resp_timeout = 0, cnt_tan = 1.
- Separate then crossing back-to-back, same circle and line:
  - c = -3 -> resp_class = 0, then c = 0 -> resp_class = 2;
  - cnt_sep = 1, cnt_cross = 1;
  - second burst starts at least 2 cycles after the first out_valid.
- Timeout: bench never asserts rcl_out_valid -> resp_valid after 16 WAIT cycles with resp_class = 3, resp_timeout = 1, all counters unchanged.
- Backpressure: resp_ready held low 3 cycles -> resp_valid and resp_class stable, req_ready = 0 throughout, one transfer when resp_ready rises.
- Stray and reset:
  - rcl_out_valid pulsed in IDLE -> stray_err = 1, counters unchanged;
  - rst_n asserted during SEND1 -> rcl_in_valid = 0 immediately, and after release state is IDLE with req_ready = 1 and stray_err = 0.

Source files
------------

// File: rtl/rcl_pkg.sv
// Shared encodings for the RCL initiator: FSM states, coefficient width, result codes.
// Pure declarations; no timing or flow control of its own.
package rcl_pkg;
    localparam int COEF_W = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEND0 = 3'd1;
    localparam logic [2:0] ST_SEND1 = 3'd2;
    localparam logic [2:0] ST_SEND2 = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [1:0] REL_SEP     = 2'd0;
    localparam logic [1:0] REL_TAN     = 2'd1;
    localparam logic [1:0] REL_CROSS   = 2'd2;
    localparam logic [1:0] REL_TIMEOUT = 2'd3;

    typedef logic [COEF_W-1:0] coef_t;

    // Beats 1 and 2 of the burst; beat 0 is sent straight from the request inputs.
    typedef struct packed {
        coef_t n;
        coef_t k;
        coef_t b;
        coef_t c;
    } req_tail_t;
endpackage

// File: rtl/rcl_sat_cnt.sv
// Saturating up-counter with enable: sticks at all-ones instead of wrapping.
// One-cycle update latency; no backpressure.
module rcl_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/rcl_driver.sv
// Serializes one circle/line request into the 3-beat RCL burst and returns the result or a timeout.
// Burst starts the cycle after acceptance; one request in flight; response held until resp_ready.
module rcl_driver
    import rcl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_m,
    input  logic [4:0]        req_n,
    input  logic [4:0]        req_k,
    input  logic [4:0]        req_a,
    input  logic [4:0]        req_b,
    input  logic [4:0]        req_c,
    output logic              rcl_in_valid,
    output logic [4:0]        rcl_coef_Q,
    output logic [4:0]        rcl_coef_L,
    input  logic              rcl_out_valid,
    input  logic [1:0]        rcl_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_class,
    output logic              resp_timeout,
    output logic              stray_err,
    output logic [CNT_W-1:0]  cnt_sep,
    output logic [CNT_W-1:0]  cnt_tan,
    output logic [CNT_W-1:0]  cnt_cross
);
    logic [2:0]  r_state;
    req_tail_t   r_req;
    logic        r_in_valid;
    coef_t       r_coef_q;
    coef_t       r_coef_l;
    logic [7:0]  r_wcnt;
    logic        r_resp_valid;
    logic [1:0]  r_resp_class;
    logic        r_resp_timeout;
    logic        r_stray;

    logic        w_result;
    logic        w_expire;

    assign w_result = (r_state == ST_WAIT) && rcl_out_valid;
    assign w_expire = (r_state == ST_WAIT) && (r_wcnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_req          <= '0;
            r_in_valid     <= 1'b0;
            r_coef_q       <= '0;
            r_coef_l       <= '0;
            r_wcnt         <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_class   <= '0;
            r_resp_timeout <= 1'b0;
            r_stray        <= 1'b0;
        end else begin
            if (rcl_out_valid && (r_state != ST_WAIT)) begin
                r_stray <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req      <= '{n: req_n, k: req_k, b: req_b, c: req_c};
                        r_in_valid <= 1'b1;
                        r_coef_q   <= req_m;
                        r_coef_l   <= req_a;
                        r_state    <= ST_SEND0;
                    end
                end
                ST_SEND0: begin
                    r_coef_q <= r_req.n;
                    r_coef_l <= r_req.b;
                    r_state  <= ST_SEND1;
                end
                ST_SEND1: begin
                    r_coef_q <= r_req.k;
                    r_coef_l <= r_req.c;
                    r_state  <= ST_SEND2;
                end
                ST_SEND2: begin
                    r_in_valid <= 1'b0;
                    r_coef_q   <= '0;
                    r_coef_l   <= '0;
                    r_wcnt     <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the expiry cycle takes priority over the timeout.
                    if (w_result) begin
                        r_resp_class   <= rcl_out;
                        r_resp_timeout <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_state        <= ST_RESP;
                    end else if (w_expire) begin
                        r_resp_class   <= REL_TIMEOUT;
                        r_resp_timeout <= 1'b1;
                        r_resp_valid   <= 1'b1;
                        r_state        <= ST_RESP;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rcl_sat_cnt #(.W(CNT_W)) u_cnt_sep (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_result && (rcl_out == REL_SEP)),
        .o_cnt (cnt_sep)
    );

    rcl_sat_cnt #(.W(CNT_W)) u_cnt_tan (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_result && (rcl_out == REL_TAN)),
        .o_cnt (cnt_tan)
    );

    rcl_sat_cnt #(.W(CNT_W)) u_cnt_cross (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_result && (rcl_out == REL_CROSS)),
        .o_cnt (cnt_cross)
    );

    assign req_ready    = (r_state == ST_IDLE);
    assign rcl_in_valid = r_in_valid;
    assign rcl_coef_Q   = r_coef_q;
    assign rcl_coef_L   = r_coef_l;
    assign resp_valid   = r_resp_valid;
    assign resp_class   = r_resp_class;
    assign resp_timeout = r_resp_timeout;
    assign stray_err    = r_stray;
endmodule

// File: tb/tb_rcl_driver.sv
// Directed bench for rcl_driver with a behavioural RCL responder.
module tb_rcl_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_m = '0, req_n = '0, req_k = '0, req_a = '0, req_b = '0, req_c = '0;
    logic       rcl_in_valid;
    logic [4:0] rcl_coef_Q, rcl_coef_L;
    logic       rcl_out_valid = 1'b0;
    logic [1:0] rcl_out = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [1:0] resp_class;
    logic       resp_timeout;
    logic       stray_err;
    logic [7:0] cnt_sep, cnt_tan, cnt_cross;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rcl_driver #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_n(req_n), .req_k(req_k),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rcl_in_valid(rcl_in_valid), .rcl_coef_Q(rcl_coef_Q), .rcl_coef_L(rcl_coef_L),
        .rcl_out_valid(rcl_out_valid), .rcl_out(rcl_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_class(resp_class), .resp_timeout(resp_timeout),
        .stray_err(stray_err),
        .cnt_sep(cnt_sep), .cnt_tan(cnt_tan), .cnt_cross(cnt_cross)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RCL relation: squared distance of centre to line against k*(a^2+b^2).
    function automatic logic [1:0] rcl_model(input logic [4:0] m, n, k, a, b, c);
        int mi, ni, ki, ai, bi, ci, d, r;
        mi = $signed(m); ni = $signed(n); ki = int'(k);
        ai = $signed(a); bi = $signed(b); ci = $signed(c);
        d = ai * mi + bi * ni + ci;
        r = ki * (ai * ai + bi * bi);
        if (d * d > r) return 2'd0;
        if (d * d == r) return 2'd1;
        return 2'd2;
    endfunction

    // Issue one request and follow its burst up to the first WAIT cycle.
    task automatic issue(input int m, n, k, a, b, c, output logic [1:0] rel, output int start_cyc);
        logic [4:0] eq[3], el[3], sq[3], sl[3];
        eq = '{5'(m), 5'(n), 5'(k)};
        el = '{5'(a), 5'(b), 5'(c)};
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL issue_req_ready got %b want 1", req_ready);
        end
        req_m = 5'(m); req_n = 5'(n); req_k = 5'(k);
        req_a = 5'(a); req_b = 5'(b); req_c = 5'(c);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rcl_in_valid !== 1'b1 || rcl_coef_Q !== eq[i] || rcl_coef_L !== el[i]) begin
                n_err++;
                $display("FAIL burst_beat%0d got vld=%b Q=%0d L=%0d want vld=1 Q=%0d L=%0d",
                         i, rcl_in_valid, rcl_coef_Q, rcl_coef_L, eq[i], el[i]);
            end
            sq[i] = rcl_coef_Q;
            sl[i] = rcl_coef_L;
            step();
        end
        n_cmp++;
        if (rcl_in_valid !== 1'b0 || rcl_coef_Q !== 5'd0 || rcl_coef_L !== 5'd0) begin
            n_err++;
            $display("FAIL burst_end got vld=%b Q=%0d L=%0d want 0 0 0", rcl_in_valid, rcl_coef_Q, rcl_coef_L);
        end
        rel = rcl_model(sq[0], sq[1], sq[2], sl[0], sl[1], sl[2]);
    endtask

    // From WAIT cycle 1, pulse the result in WAIT cycle wc; ends in the first RESP cycle.
    task automatic answer(input int wc, input logic [1:0] r, output int out_cyc);
        repeat (wc - 1) step();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL wait_resp_valid got %b want 0", resp_valid);
        end
        rcl_out_valid = 1'b1;
        rcl_out = r;
        out_cyc = cyc;
        step();
        rcl_out_valid = 1'b0;
        rcl_out = 2'd0;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL take_resp got valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({rcl_in_valid, rcl_coef_Q, rcl_coef_L, resp_valid, resp_class, resp_timeout, stray_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got vld=%b Q=%0d L=%0d rv=%b cls=%0d to=%b stray=%b want all 0",
                     rcl_in_valid, rcl_coef_Q, rcl_coef_L, resp_valid, resp_class, resp_timeout, stray_err);
        end
        n_cmp++;
        if (cnt_sep !== 8'd0 || cnt_tan !== 8'd0 || cnt_cross !== 8'd0) begin
            n_err++; $display("FAIL reset_counters got %0d %0d %0d want 0 0 0", cnt_sep, cnt_tan, cnt_cross);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
    endtask

    // Tangent result, then resp_ready held low for three cycles.
    task automatic test_tangent_backpressure();
        logic [1:0] rel;
        int sc, oc;
        issue(0, 0, 4, 1, 0, -2, rel, sc);
        answer(5, rel, oc);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_class !== 2'd1 || resp_timeout !== 1'b0 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL tan_hold%0d got rv=%b cls=%0d to=%b rr=%b want 1 1 0 0",
                         i, resp_valid, resp_class, resp_timeout, req_ready);
            end
            step();
        end
        n_cmp++;
        if (cnt_tan !== 8'd1 || cnt_sep !== 8'd0 || cnt_cross !== 8'd0) begin
            n_err++; $display("FAIL tan_counters got sep=%0d tan=%0d cross=%0d want 0 1 0", cnt_sep, cnt_tan, cnt_cross);
        end
        take_resp();
        step();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL tan_single_transfer got %b want 0", resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rel;
        int sc, oc;
        issue(0, 0, 4, 1, 0, -3, rel, sc);
        answer(5, rel, oc);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_class !== 2'd0 || resp_timeout !== 1'b0) begin
            n_err++; $display("FAIL b2b_sep got rv=%b cls=%0d to=%b want 1 0 0", resp_valid, resp_class, resp_timeout);
        end
        take_resp();
        issue(0, 0, 4, 1, 0, 0, rel, sc);
        n_cmp++;
        if (sc - oc < 2) begin
            n_err++; $display("FAIL b2b_gap got %0d cycles want >= 2", sc - oc);
        end
        answer(5, rel, oc);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_class !== 2'd2 || resp_timeout !== 1'b0) begin
            n_err++; $display("FAIL b2b_cross got rv=%b cls=%0d to=%b want 1 2 0", resp_valid, resp_class, resp_timeout);
        end
        n_cmp++;
        if (cnt_sep !== 8'd1 || cnt_tan !== 8'd1 || cnt_cross !== 8'd1) begin
            n_err++; $display("FAIL b2b_counters got %0d %0d %0d want 1 1 1", cnt_sep, cnt_tan, cnt_cross);
        end
        take_resp();
    endtask

    task automatic test_timeout();
        logic [1:0] rel;
        int sc;
        issue(0, 0, 4, 1, 0, -2, rel, sc);
        repeat (15) step();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL timeout_early got %b want 0 in WAIT cycle 16", resp_valid);
        end
        step();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_class !== 2'd3 || resp_timeout !== 1'b1) begin
            n_err++; $display("FAIL timeout_resp got rv=%b cls=%0d to=%b want 1 3 1", resp_valid, resp_class, resp_timeout);
        end
        n_cmp++;
        if (cnt_sep !== 8'd1 || cnt_tan !== 8'd1 || cnt_cross !== 8'd1) begin
            n_err++; $display("FAIL timeout_counters got %0d %0d %0d want 1 1 1", cnt_sep, cnt_tan, cnt_cross);
        end
        take_resp();
    endtask

    task automatic test_rel3();
        logic [1:0] rel;
        int sc, oc;
        issue(1, 1, 9, 1, 1, 1, rel, sc);
        answer(5, 2'd3, oc);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_class !== 2'd3 || resp_timeout !== 1'b0) begin
            n_err++; $display("FAIL rel3_resp got rv=%b cls=%0d to=%b want 1 3 0", resp_valid, resp_class, resp_timeout);
        end
        n_cmp++;
        if (cnt_sep !== 8'd1 || cnt_tan !== 8'd1 || cnt_cross !== 8'd1) begin
            n_err++; $display("FAIL rel3_counters got %0d %0d %0d want 1 1 1", cnt_sep, cnt_tan, cnt_cross);
        end
        take_resp();
    endtask

    // Result lands on the same cycle the timeout would fire.
    task automatic test_simultaneous();
        logic [1:0] rel;
        int sc, oc;
        issue(0, 0, 4, 1, 0, -2, rel, sc);
        answer(16, rel, oc);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_class !== 2'd1 || resp_timeout !== 1'b0) begin
            n_err++; $display("FAIL simul_resp got rv=%b cls=%0d to=%b want 1 1 0", resp_valid, resp_class, resp_timeout);
        end
        n_cmp++;
        if (cnt_tan !== 8'd2) begin
            n_err++; $display("FAIL simul_cnt_tan got %0d want 2", cnt_tan);
        end
        take_resp();
    endtask

    task automatic test_stray();
        rcl_out_valid = 1'b1;
        rcl_out = 2'd2;
        step();
        rcl_out_valid = 1'b0;
        rcl_out = 2'd0;
        n_cmp++;
        if (stray_err !== 1'b1) begin
            n_err++; $display("FAIL stray_flag got %b want 1", stray_err);
        end
        n_cmp++;
        if (cnt_sep !== 8'd1 || cnt_tan !== 8'd2 || cnt_cross !== 8'd1 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_side_effect got %0d %0d %0d rr=%b rv=%b want 1 2 1 1 0",
                     cnt_sep, cnt_tan, cnt_cross, req_ready, resp_valid);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] rel;
        int sc, oc;
        for (int i = 0; i < 260; i++) begin
            issue(0, 0, 4, 1, 0, -2, rel, sc);
            answer(5, rel, oc);
            take_resp();
        end
        n_cmp++;
        if (cnt_tan !== 8'hFF || cnt_sep !== 8'd1 || cnt_cross !== 8'd1) begin
            n_err++; $display("FAIL saturate got sep=%0d tan=%0d cross=%0d want 1 255 1", cnt_sep, cnt_tan, cnt_cross);
        end
        n_cmp++;
        if (stray_err !== 1'b1) begin
            n_err++; $display("FAIL stray_sticky got %b want 1", stray_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        req_m = 5'd3; req_n = 5'd2; req_k = 5'd1; req_a = 5'd1; req_b = 5'd1; req_c = 5'd1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        n_cmp++;
        if (rcl_in_valid !== 1'b1 || rcl_coef_Q !== 5'd2) begin
            n_err++; $display("FAIL midrst_send1 got vld=%b Q=%0d want 1 2", rcl_in_valid, rcl_coef_Q);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rcl_in_valid !== 1'b0 || rcl_coef_Q !== 5'd0 || cnt_tan !== 8'd0) begin
            n_err++; $display("FAIL midrst_async got vld=%b Q=%0d tan=%0d want 0 0 0", rcl_in_valid, rcl_coef_Q, cnt_tan);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || rcl_in_valid !== 1'b0 || stray_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_release got rr=%b vld=%b stray=%b want 1 0 0", req_ready, rcl_in_valid, stray_err);
        end
    endtask

    initial begin
        test_reset();
        test_tangent_backpressure();
        test_back_to_back();
        test_timeout();
        test_rel3();
        test_simultaneous();
        test_stray();
        test_saturate();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
